// File: rtl/blit_arbiter_pkg.sv
// Shared screen geometry, pixel field widths and blit FSM state encodings
// for the sprite blit arbiter and its helpers.
package blit_arbiter_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } blit_state_e;

endpackage

// File: rtl/blit_arbiter_rr.sv
// Combinational round-robin picker: searches upward from pointer with wrap
// and returns the first active request as one-hot plus its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic        found;
  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = int'(pointer) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (enable && !found && req[IDX_W'(cand)]) begin
        found                  = 1'b1;
        grant[IDX_W'(cand)]    = 1'b1;
        grant_idx              = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/blit_arbiter.sv
// Round-robin sprite blitter: scans a 1-bit sprite from ROM and drives the
// vga_adapter plot port with coordinates aligned to the ROM read latency.
module blit_arbiter
  import blit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned SPR_W   = 32,
  parameter int unsigned SPR_H   = 32,
  parameter int unsigned ADDR_W  = 15
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       req_x0,
  input  logic [NUM_REQ*Y_W-1:0]       req_y0,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_base,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_fg,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_bg,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic                         rom_q,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned COL_W = $clog2(SPR_W + 1);
  localparam int unsigned ROW_W = $clog2(SPR_H + 1);

  blit_state_e         state;
  logic [IDX_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;

  logic [X_W-1:0]      x0_arr   [NUM_REQ];
  logic [Y_W-1:0]      y0_arr   [NUM_REQ];
  logic [ADDR_W-1:0]   base_arr [NUM_REQ];
  logic [COLOUR_W-1:0] fg_arr   [NUM_REQ];
  logic [COLOUR_W-1:0] bg_arr   [NUM_REQ];

  logic [X_W-1:0]      lat_x0;
  logic [Y_W-1:0]      lat_y0;
  logic [ADDR_W-1:0]   lat_base;
  logic [COLOUR_W-1:0] lat_fg;
  logic [COLOUR_W-1:0] lat_bg;

  logic [COL_W-1:0]    col, ncol;
  logic [ROW_W-1:0]    row, nrow;
  logic                col_last, row_last;
  logic [ADDR_W-1:0]   next_addr;
  logic [X_W:0]        x9;
  logic [Y_W:0]        y8;

  logic                pix_valid;
  logic                pix_clip;
  logic [COLOUR_W-1:0] colour_hold;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign x0_arr[i]   = req_x0[i*X_W +: X_W];
    assign y0_arr[i]   = req_y0[i*Y_W +: Y_W];
    assign base_arr[i] = req_base[i*ADDR_W +: ADDR_W];
    assign fg_arr[i]   = req_fg[i*COLOUR_W +: COLOUR_W];
    assign bg_arr[i]   = req_bg[i*COLOUR_W +: COLOUR_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req),
    .pointer   (ptr),
    .enable    (state == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    col_last  = (col == COL_W'(SPR_W - 1));
    row_last  = (row == ROW_W'(SPR_H - 1));
    ncol      = col_last ? '0 : col + 1'b1;
    nrow      = col_last ? row + 1'b1 : row;
    next_addr = lat_base + ADDR_W'(nrow) * ADDR_W'(SPR_W) + ADDR_W'(ncol);
    x9        = {1'b0, lat_x0} + (X_W+1)'(col);
    y8        = {1'b0, lat_y0} + (Y_W+1)'(row);
  end

  // The pipe stage is registered at the same edge the ROM latches its address,
  // so coords and rom_q line up; colour is resolved combinationally from rom_q.
  assign colour = pix_valid ? (rom_q ? lat_fg : lat_bg) : colour_hold;
  assign plot   = pix_valid & ~pix_clip;
  assign done   = (state == DRAIN) ? grant : '0;
  assign busy   = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      rom_addr    <= '0;
      lat_x0      <= '0;
      lat_y0      <= '0;
      lat_base    <= '0;
      lat_fg      <= '0;
      lat_bg      <= '0;
      col         <= '0;
      row         <= '0;
      x           <= '0;
      y           <= '0;
      pix_valid   <= 1'b0;
      pix_clip    <= 1'b0;
      colour_hold <= '0;
    end else begin
      pix_valid   <= 1'b0;
      colour_hold <= colour;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= SCAN;
            grant    <= arb_grant;
            ptr      <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            lat_x0   <= x0_arr[arb_idx];
            lat_y0   <= y0_arr[arb_idx];
            lat_base <= base_arr[arb_idx];
            lat_fg   <= fg_arr[arb_idx];
            lat_bg   <= bg_arr[arb_idx];
            rom_addr <= base_arr[arb_idx];
            col      <= '0;
            row      <= '0;
          end
        end
        SCAN: begin
          pix_valid <= 1'b1;
          x         <= x9[X_W-1:0];
          y         <= y8[Y_W-1:0];
          pix_clip  <= (x9 >= (X_W+1)'(SCREEN_W)) || (y8 >= (Y_W+1)'(SCREEN_H));
          col       <= ncol;
          row       <= nrow;
          if (col_last && row_last) state <= DRAIN;
          else                      rom_addr <= next_addr;
        end
        DRAIN: begin
          state <= IDLE;
          grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_arbiter.sv
// Scoreboard bench for blit_arbiter with a 4x2 sprite and a modelled
// single-cycle-latency ROM.
module tb_blit_arbiter;

  localparam int NR = 3;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int AW = 15;
  localparam int WH = SW * SH;

  typedef struct {
    logic [2:0]  owner;
    logic [14:0] base;
  } blit_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       last;
  } pix_t;

  logic          clock;
  logic          reset_n;
  logic [2:0]    req;
  logic [23:0]   req_x0;
  logic [20:0]   req_y0;
  logic [44:0]   req_base;
  logic [8:0]    req_fg;
  logic [8:0]    req_bg;
  logic [2:0]    grant;
  logic [2:0]    done;
  logic          busy;
  logic [14:0]   rom_addr;
  logic          rom_q;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [2:0]    colour;
  logic          plot;

  int    n_cmp = 0;
  int    n_err = 0;
  int    rom_mode = 0;
  bit    mon_en = 0;
  blit_t blit_q[$];
  pix_t  pix_q[$];
  int    sx0[NR], sy0[NR], sbase[NR], sfg[NR], sbg[NR];

  blit_arbiter #(.NUM_REQ(NR), .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .req_x0   (req_x0),
    .req_y0   (req_y0),
    .req_base (req_base),
    .req_fg   (req_fg),
    .req_bg   (req_bg),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic rom_fn(input logic [14:0] a);
    case (rom_mode)
      0:       return 1'b1;
      1:       return ~a[0];
      default: return a[0] ^ a[2] ^ a[3];
    endcase
  endfunction

  always @(posedge clock) rom_q <= rom_fn(rom_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_slot(input int s, input int x0, input int y0, input int base,
                           input int fg, input int bg);
    sx0[s] = x0; sy0[s] = y0; sbase[s] = base; sfg[s] = fg; sbg[s] = bg;
    req_x0[s*8 +: 8]    = 8'(x0);
    req_y0[s*7 +: 7]    = 7'(y0);
    req_base[s*15 +: 15] = 15'(base);
    req_fg[s*3 +: 3]    = 3'(fg);
    req_bg[s*3 +: 3]    = 3'(bg);
  endtask

  task automatic expect_blit(input int s);
    blit_t b;
    pix_t  p;
    int    ex, ey;
    logic [14:0] a;
    b.owner = 3'(1 << s);
    b.base  = 15'(sbase[s]);
    blit_q.push_back(b);
    for (int k = 0; k < WH; k++) begin
      ex       = sx0[s] + (k % SW);
      ey       = sy0[s] + (k / SW);
      a        = 15'(sbase[s] + k);
      p.x      = 8'(ex);
      p.y      = 7'(ey);
      p.colour = rom_fn(a) ? 3'(sfg[s]) : 3'(sbg[s]);
      p.plot   = (ex < 160) && (ey < 120);
      p.last   = (k == WH - 1);
      pix_q.push_back(p);
    end
  endtask

  task automatic wait_all(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      req = req & ~done;
      if (req == '0 && !busy && pix_q.size() == 0 && blit_q.size() == 0) break;
    end
    check_val("drain_queue", 32'(pix_q.size() + blit_q.size()), 32'd0);
    check_val("drain_busy", 32'(busy), 32'd0);
  endtask

  // Output monitor: pops expectations as the DUT presents grants and pixels.
  initial begin
    logic [2:0]  prev_g;
    logic [2:0]  cur_owner;
    logic [14:0] cur_base;
    int          pix_n;
    blit_t       b;
    pix_t        p;
    prev_g = '0; cur_owner = '0; cur_base = '0; pix_n = 0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (grant != '0 && prev_g == '0) begin
          if (blit_q.size() == 0) check_val("unexpected_grant", 32'(grant), 32'd0);
          else begin
            b = blit_q.pop_front();
            cur_owner = b.owner; cur_base = b.base; pix_n = 0;
            check_val("grant", 32'(grant), 32'(b.owner));
            check_val("first_addr", 32'(rom_addr), 32'(b.base));
            check_val("busy_hi", 32'(busy), 32'd1);
            check_val("plot_pre", 32'(plot), 32'd0);
          end
        end else if (grant != '0) begin
          if (pix_q.size() == 0) check_val("extra_pixel", 32'(grant), 32'd0);
          else begin
            p = pix_q.pop_front();
            check_val("grant_hold", 32'(grant), 32'(cur_owner));
            check_val("pix_x", 32'(x), 32'(p.x));
            check_val("pix_y", 32'(y), 32'(p.y));
            check_val("pix_colour", 32'(colour), 32'(p.colour));
            check_val("pix_plot", 32'(plot), 32'(p.plot));
            check_val("done", 32'(done), p.last ? 32'(cur_owner) : 32'd0);
            if (pix_n + 1 < WH)
              check_val("rom_addr", 32'(rom_addr), 32'(15'(cur_base + 15'(pix_n + 1))));
            pix_n++;
          end
        end else if (prev_g != '0) begin
          check_val("post_busy", 32'(busy), 32'd0);
          check_val("post_plot", 32'(plot), 32'd0);
          check_val("post_done", 32'(done), 32'd0);
        end
      end
      prev_g = grant;
    end
  end

  initial begin
    reset_n = 1'b0; req = '0;
    req_x0 = '0; req_y0 = '0; req_base = '0; req_fg = '0; req_bg = '0;
    repeat (3) @(negedge clock);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_plot", 32'(plot), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_addr", 32'(rom_addr), 32'd0);
    check_val("rst_xyc", 32'({x, y, colour}), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clock);

    // basic 4x2 blit, ROM all ones
    rom_mode = 0;
    load_slot(0, 10, 20, 100, 3'b010, 3'b101);
    expect_blit(0);
    req = 3'b001;
    wait_all(40);

    // alternating ROM checks colour/x alignment; pointer now moves to 0
    rom_mode = 1;
    load_slot(2, 40, 50, 200, 7, 0);
    expect_blit(2);
    req = 3'b100;
    wait_all(40);

    // all three at once, then 0 and 2 together; base near top wraps address
    rom_mode = 2;
    load_slot(0, 5, 5, 300, 1, 6);
    load_slot(1, 60, 30, 32764, 4, 2);
    load_slot(2, 100, 100, 0, 5, 3);
    expect_blit(0); expect_blit(1); expect_blit(2);
    req = 3'b111;
    wait_all(80);
    load_slot(0, 12, 7, 800, 2, 1);
    load_slot(2, 90, 60, 900, 6, 4);
    expect_blit(0); expect_blit(2);
    req = 3'b101;
    wait_all(60);

    // clipped at bottom-right corner
    rom_mode = 0;
    load_slot(1, 158, 119, 400, 3, 4);
    expect_blit(1);
    req = 3'b010;
    wait_all(40);

    // origin changed mid-blit must be ignored
    rom_mode = 2;
    load_slot(0, 30, 40, 500, 7, 1);
    expect_blit(0);
    req = 3'b001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (grant != '0) break;
    end
    req_x0[7:0] = 8'd50;
    wait_all(40);

    // reset in the third SCAN cycle abandons the blit
    mon_en   = 1'b0;
    rom_mode = 0;
    load_slot(0, 70, 80, 600, 2, 5);
    load_slot(1, 20, 10, 700, 6, 1);
    req = 3'b001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (grant != '0) break;
    end
    check_val("rst_mid_grant_seen", 32'(grant), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    req[1]  = 1'b1;
    @(negedge clock);
    check_val("rst_mid_grant", 32'(grant), 32'd0);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_plot", 32'(plot), 32'd0);
    check_val("rst_mid_done", 32'(done), 32'd0);
    check_val("rst_mid_addr", 32'(rom_addr), 32'd0);
    expect_blit(0); expect_blit(1);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    wait_all(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
